// File: rtl/utlb_pkg.sv
// Shared types for the micro-TLB: FSM states, fault codes, entry layout and
// the fault priority encoder applied to joint-TLB results.
package utlb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOOK = 2'd1,
        XLAT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] FAULT_NONE  = 3'd0;
    localparam logic [2:0] FAULT_MISS  = 3'd1;
    localparam logic [2:0] FAULT_ADE   = 3'd2;
    localparam logic [2:0] FAULT_INVAL = 3'd3;
    localparam logic [2:0] FAULT_MOD   = 3'd4;

    typedef struct packed {
        logic        valid;
        logic [51:0] tag;
        logic [19:0] pfn;
        logic        cache;
        logic        wok;
    } entry_t;

    // Address error outranks miss, miss outranks invalid, invalid outranks modify.
    function automatic logic [2:0] fault_code(input logic ade, input logic miss,
                                              input logic inval, input logic mod);
        if (ade)        return FAULT_ADE;
        else if (miss)  return FAULT_MISS;
        else if (inval) return FAULT_INVAL;
        else if (mod)   return FAULT_MOD;
        else            return FAULT_NONE;
    endfunction

endpackage

// File: rtl/utlb_cam.sv
// Fully-associative entry store: tag compare producing a match vector and the
// matching entry's payload, one write port, and a bulk invalidate.
module utlb_cam
    import utlb_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int IW      = $clog2(ENTRIES)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic [51:0]   lookup_tag,
    output logic          match_any,
    output logic [IW-1:0] match_idx,
    output logic [19:0]   hit_pfn,
    output logic          hit_cache,
    output logic          hit_wok,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  logic [51:0]   wtag,
    input  logic [19:0]   wpfn,
    input  logic          wcache,
    input  logic          wwok
);

    entry_t ent [ENTRIES];

    // Fill logic guarantees tags are unique, so at most one entry matches.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        hit_pfn   = '0;
        hit_cache = 1'b0;
        hit_wok   = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (ent[i].valid && ent[i].tag == lookup_tag) begin
                match_any = 1'b1;
                match_idx = IW'(i);
                hit_pfn   = ent[i].pfn;
                hit_cache = ent[i].cache;
                hit_wok   = ent[i].wok;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ENTRIES; i++) ent[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) ent[i].valid <= 1'b0;
        end else if (we) begin
            ent[widx] <= '{valid: 1'b1, tag: wtag, pfn: wpfn, cache: wcache, wok: wwok};
        end
    end

endmodule

// File: rtl/utlb.sv
// Micro-TLB in front of the joint TLB. Handshake: req is held with va/wr
// stable until ack; ack is a one-cycle pulse carrying pa/cache/fault.
module utlb
    import utlb_pkg::*;
#(
    parameter int ENTRIES = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req,
    input  logic [63:0] va,
    input  logic        wr,
    output logic        ack,
    output logic [31:0] pa,
    output logic        cache,
    output logic [2:0]  fault,
    input  logic        flush,
    output logic [63:0] jtlbva,
    output logic        jtlbreq,
    output logic        jtlbwr,
    input  logic [31:0] jtlbpa,
    input  logic        jtlbcache,
    input  logic        jtlbmiss,
    input  logic        jtlbade,
    input  logic        jtlbinval,
    input  logic        jtlbmod,
    output state_t      state
);

    localparam int IW = $clog2(ENTRIES);

    state_t        state_n;
    logic [63:0]   va_q;
    logic          wr_q;
    logic [IW-1:0] ptr;
    logic          match_any;
    logic [IW-1:0] match_idx;
    logic [19:0]   hit_pfn;
    logic          hit_cache;
    logic          hit_wok;
    logic          hit;
    logic [2:0]    jfault;
    logic          fill;
    logic [IW-1:0] fill_idx;

    utlb_cam #(.ENTRIES(ENTRIES), .IW(IW)) u_cam (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .lookup_tag (va_q[63:12]),
        .match_any  (match_any),
        .match_idx  (match_idx),
        .hit_pfn    (hit_pfn),
        .hit_cache  (hit_cache),
        .hit_wok    (hit_wok),
        .we         (fill),
        .widx       (fill_idx),
        .wtag       (va_q[63:12]),
        .wpfn       (jtlbpa[31:12]),
        .wcache     (jtlbcache),
        .wwok       (wr_q)
    );

    // A flush landing on the lookup cycle forces the miss path.
    assign hit      = match_any && (!wr_q || hit_wok) && !flush;
    assign jfault   = fault_code(jtlbade, jtlbmiss, jtlbinval, jtlbmod);
    assign fill     = (state == XLAT) && (jfault == FAULT_NONE) && !flush;
    // A store upgrading a clean read page reuses that slot.
    assign fill_idx = match_any ? match_idx : ptr;

    assign ack     = (state == DONE);
    assign jtlbreq = (state == XLAT);
    assign jtlbva  = va_q;
    assign jtlbwr  = wr_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req) state_n = LOOK;
            LOOK:    state_n = hit ? DONE : XLAT;
            XLAT:    state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            va_q  <= '0;
            wr_q  <= 1'b0;
            ptr   <= '0;
            pa    <= '0;
            cache <= 1'b0;
            fault <= FAULT_NONE;
        end else begin
            if (state == IDLE && req) begin
                va_q <= va;
                wr_q <= wr;
            end
            if (state == LOOK && hit) begin
                pa    <= {hit_pfn, va_q[11:0]};
                cache <= hit_cache;
                fault <= FAULT_NONE;
            end
            if (state == XLAT) begin
                fault <= jfault;
                if (jfault == FAULT_NONE) begin
                    pa    <= (jtlbpa & 32'hFFFF_F000) | {20'd0, va_q[11:0]};
                    cache <= jtlbcache;
                end else begin
                    pa    <= '0;
                    cache <= 1'b0;
                end
                if (fill && !match_any)
                    ptr <= (ptr == IW'(ENTRIES - 1)) ? '0 : ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_utlb.sv
// Self-checking bench for utlb: directed scenarios with a response scoreboard
// and a behavioural joint-TLB driven from the test tasks.
module tb_utlb;
    import utlb_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req = 1'b0;
    logic [63:0] va = '0;
    logic        wr = 1'b0;
    logic        flush = 1'b0;
    logic        ack;
    logic [31:0] pa;
    logic        cache;
    logic [2:0]  fault;
    logic [63:0] jtlbva;
    logic        jtlbreq;
    logic        jtlbwr;
    logic [31:0] jtlbpa = '0;
    logic        jtlbcache = 1'b0;
    logic        jtlbmiss = 1'b0;
    logic        jtlbade = 1'b0;
    logic        jtlbinval = 1'b0;
    logic        jtlbmod = 1'b0;
    state_t      state;

    int tests_run = 0;
    int tests_failed = 0;
    logic [35:0] exp_q[$];
    logic [35:0] mon_e;

    utlb #(.ENTRIES(4)) dut (
        .clk(clk), .rstn(rstn), .req(req), .va(va), .wr(wr),
        .ack(ack), .pa(pa), .cache(cache), .fault(fault), .flush(flush),
        .jtlbva(jtlbva), .jtlbreq(jtlbreq), .jtlbwr(jtlbwr),
        .jtlbpa(jtlbpa), .jtlbcache(jtlbcache), .jtlbmiss(jtlbmiss),
        .jtlbade(jtlbade), .jtlbinval(jtlbinval), .jtlbmod(jtlbmod),
        .state(state)
    );

    always #5 clk = ~clk;

    // Scoreboard: every ack pops one expected {pa, cache, fault}.
    always @(negedge clk) begin
        if (ack === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL ack_unexpected: ack=1 with no pending request");
            end else begin
                mon_e = exp_q.pop_front();
                if (fault !== mon_e[2:0]) begin
                    tests_failed++;
                    $display("FAIL fault: got %0d want %0d", fault, mon_e[2:0]);
                end
                if (mon_e[2:0] == FAULT_NONE) begin
                    tests_run++;
                    if (pa !== mon_e[35:4] || cache !== mon_e[3]) begin
                        tests_failed++;
                        $display("FAIL pa_cache: got %h/%b want %h/%b", pa, cache, mon_e[35:4], mon_e[3]);
                    end
                end
            end
        end
    end

    task automatic set_jtlb(input logic [31:0] p, input logic c, input logic [3:0] f);
        jtlbpa = p; jtlbcache = c;
        {jtlbade, jtlbmiss, jtlbinval, jtlbmod} = f;
    endtask

    task automatic do_req(input logic [63:0] a, input logic w, input logic [31:0] epa,
                          input logic ec, input logic [2:0] ef, input int elat,
                          input int ejreq, input int flush_at, input logic drop_early);
        int lat, jcnt;
        logic got;
        lat = 0; jcnt = 0; got = 1'b0;
        @(negedge clk);
        exp_q.push_back({epa, ec, ef});
        req = 1'b1; va = a; wr = w;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(posedge clk);
            lat = c;
            @(negedge clk);
            flush = 1'b0;
            if (drop_early) begin
                req = 1'b0;
                va = {$urandom(), $urandom()};
                wr = ~w;
            end
            if (jtlbreq === 1'b1) begin
                jcnt++;
                tests_run++;
                if (jtlbva !== a || jtlbwr !== w) begin
                    tests_failed++;
                    $display("FAIL jtlb_addr: got %h/%b want %h/%b", jtlbva, jtlbwr, a, w);
                end
            end
            if (c == flush_at) flush = 1'b1;
            if (ack === 1'b1) got = 1'b1;
        end
        req = 1'b0; flush = 1'b0;
        tests_run++;
        if (!got || lat != elat) begin
            tests_failed++;
            $display("FAIL latency va=%h: got %0d (acked=%b) want %0d", a, lat, got, elat);
        end
        tests_run++;
        if (jcnt != ejreq) begin
            tests_failed++;
            $display("FAIL jtlbreq_count va=%h: got %0d want %0d", a, jcnt, ejreq);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        tests_run++;
        if (ack !== 1'b0 || jtlbreq !== 1'b0 || fault !== 3'd0 || cache !== 1'b0 ||
            pa !== 32'd0 || jtlbva !== 64'd0 || jtlbwr !== 1'b0 || state !== IDLE) begin
            tests_failed++;
            $display("FAIL %s: ack=%b jreq=%b fault=%0d cache=%b pa=%h jva=%h jwr=%b st=%0d want all zero/IDLE",
                     tag, ack, jtlbreq, fault, cache, pa, jtlbva, jtlbwr, state);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_hold");
        rstn = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_release");
    endtask

    task automatic test_miss_then_hit;
        set_jtlb(32'h0123_4000, 1'b1, 4'b0000);
        do_req(64'h0000_0000_0040_1234, 1'b0, 32'h0123_4234, 1'b1, FAULT_NONE, 3, 1, 0, 1'b0);
        set_jtlb(32'hDEAD_B000, 1'b0, 4'b0000);
        do_req(64'h0000_0000_0040_1FFC, 1'b0, 32'h0123_4FFC, 1'b1, FAULT_NONE, 2, 0, 0, 1'b0);
    endtask

    task automatic test_store_upgrade;
        set_jtlb(32'h0999_9000, 1'b1, 4'b0001);
        do_req(64'h0000_0000_0040_1010, 1'b1, 32'h0, 1'b0, FAULT_MOD, 3, 1, 0, 1'b0);
        do_req(64'h0000_0000_0040_1000, 1'b0, 32'h0123_4000, 1'b1, FAULT_NONE, 2, 0, 0, 1'b0);
        set_jtlb(32'h0555_5000, 1'b0, 4'b0000);
        do_req(64'h0000_0000_0040_1020, 1'b1, 32'h0555_5020, 1'b0, FAULT_NONE, 3, 1, 0, 1'b0);
        set_jtlb(32'h0EEE_E000, 1'b1, 4'b0000);
        do_req(64'h0000_0000_0040_1030, 1'b1, 32'h0555_5030, 1'b0, FAULT_NONE, 2, 0, 0, 1'b0);
        do_req(64'h0000_0000_0040_1040, 1'b0, 32'h0555_5040, 1'b0, FAULT_NONE, 2, 0, 0, 1'b0);
    endtask

    task automatic test_flush_idle;
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        set_jtlb(32'h0777_7000, 1'b1, 4'b0000);
        do_req(64'h0000_0000_0040_1000, 1'b0, 32'h0777_7000, 1'b1, FAULT_NONE, 3, 1, 0, 1'b0);
    endtask

    task automatic test_evict;
        logic [63:0] base;
        logic [11:0] off;
        base = 64'h8000_0000_1000_0000;
        for (int i = 0; i < 5; i++) begin
            off = 12'($urandom_range(0, 4095));
            set_jtlb(32'h1000_0000 + 32'(i << 12), 1'(i & 1), 4'b0000);
            do_req(base + 64'(i << 12) + 64'(off), 1'b0, 32'h1000_0000 + 32'(i << 12) + 32'(off),
                   1'(i & 1), FAULT_NONE, 3, 1, 0, 1'b0);
        end
        set_jtlb(32'h2000_0000, 1'b1, 4'b0000);
        for (int i = 4; i >= 1; i--) begin
            off = 12'($urandom_range(0, 4095));
            do_req(base + 64'(i << 12) + 64'(off), 1'b0, 32'h1000_0000 + 32'(i << 12) + 32'(off),
                   1'(i & 1), FAULT_NONE, 2, 0, 0, 1'b0);
        end
        do_req(base + 64'h0AB, 1'b0, 32'h2000_00AB, 1'b1, FAULT_NONE, 3, 1, 0, 1'b0);
    endtask

    task automatic test_flush_race;
        logic [63:0] f;
        f = 64'h4242_0000_0000_5000;
        set_jtlb(32'h0ABC_D000, 1'b1, 4'b0000);
        do_req(f + 64'h11, 1'b0, 32'h0ABC_D011, 1'b1, FAULT_NONE, 3, 1, 2, 1'b0);
        do_req(f + 64'h22, 1'b0, 32'h0ABC_D022, 1'b1, FAULT_NONE, 3, 1, 0, 1'b0);
        do_req(f + 64'h33, 1'b0, 32'h0ABC_D033, 1'b1, FAULT_NONE, 2, 0, 0, 1'b0);
        do_req(f + 64'h44, 1'b0, 32'h0ABC_D044, 1'b1, FAULT_NONE, 3, 1, 1, 1'b0);
    endtask

    task automatic test_fault_priority;
        logic [63:0] g;
        g = 64'h0000_7000_0000_3000;
        set_jtlb(32'h0BAD_0000, 1'b1, 4'b1100);
        do_req(g, 1'b0, 32'h0, 1'b0, FAULT_ADE, 3, 1, 0, 1'b0);
        set_jtlb(32'h0BAD_0000, 1'b1, 4'b0110);
        do_req(g, 1'b0, 32'h0, 1'b0, FAULT_MISS, 3, 1, 0, 1'b0);
        set_jtlb(32'h0BAD_0000, 1'b1, 4'b0011);
        do_req(g, 1'b1, 32'h0, 1'b0, FAULT_INVAL, 3, 1, 0, 1'b0);
        set_jtlb(32'h0C0C_0000, 1'b0, 4'b0000);
        do_req(g + 64'h7, 1'b0, 32'h0C0C_0007, 1'b0, FAULT_NONE, 3, 1, 0, 1'b0);
    endtask

    task automatic test_drop_early;
        logic [63:0] h;
        h = 64'h0000_0001_2345_6000;
        set_jtlb(32'h0F0F_0000, 1'b1, 4'b0000);
        do_req(h + 64'h321, 1'b1, 32'h0F0F_0321, 1'b1, FAULT_NONE, 3, 1, 0, 1'b1);
        do_req(h + 64'h654, 1'b1, 32'h0F0F_0654, 1'b1, FAULT_NONE, 2, 0, 0, 1'b1);
    endtask

    task automatic test_reset_mid_xlat;
        logic found;
        found = 1'b0;
        @(negedge clk);
        req = 1'b1; va = 64'h0000_0000_00AA_B000; wr = 1'b0;
        set_jtlb(32'h0333_3000, 1'b1, 4'b0000);
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (jtlbreq === 1'b1) found = 1'b1;
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL reach_xlat: jtlbreq never rose within 10 cycles");
        end
        rstn = 1'b0; req = 1'b0;
        #1;
        check_reset_outputs("reset_mid_xlat");
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_mid_xlat_hold");
        rstn = 1'b1;
        // The previously hit page must now miss.
        set_jtlb(32'h0444_4000, 1'b0, 4'b0000);
        do_req(64'h0000_0001_2345_6ABC, 1'b0, 32'h0444_4ABC, 1'b0, FAULT_NONE, 3, 1, 0, 1'b0);
    endtask

    initial begin
        test_reset;
        test_miss_then_hit;
        test_store_upgrade;
        test_flush_idle;
        test_evict;
        test_flush_race;
        test_fault_priority;
        test_drop_early;
        test_reset_mid_xlat;
        repeat (3) @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL pending_acks: got %0d outstanding want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
